// File: rtl/pwm_pkg.sv
// Shared PWM definitions: controller state encoding and the duty range used by the PWM core.
// Duty values are unsigned DUTY_WIDTH-bit setpoints.
package pwm_pkg;

  localparam int DUTY_WIDTH = 10;

  typedef logic [DUTY_WIDTH-1:0] duty_t;

  localparam duty_t DUTY_MIN = duty_t'(31);
  localparam duty_t DUTY_MAX = duty_t'(993);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_slew_step.sv
// Combinational slew limiter: moves current toward target by at most max_step,
// then clamps the result into [DUTY_MIN, DUTY_MAX].
module pwm_slew_step
  import pwm_pkg::*;
(
  input  logic [DUTY_WIDTH-1:0] current,
  input  logic [DUTY_WIDTH-1:0] target,
  input  logic [DUTY_WIDTH-1:0] max_step,
  output logic [DUTY_WIDTH-1:0] next_duty
);

  logic signed [DUTY_WIDTH:0] diff;
  logic        [DUTY_WIDTH:0] mag;
  logic        [DUTY_WIDTH:0] stepped;

  always_comb begin
    diff    = $signed({1'b0, target}) - $signed({1'b0, current});
    mag     = diff[DUTY_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    stepped = {1'b0, target};
    // In the limited branches the step cannot pass the target, so no wrap is possible.
    if (mag > {1'b0, max_step}) begin
      if (diff[DUTY_WIDTH]) begin
        stepped = {1'b0, current} - {1'b0, max_step};
      end else begin
        stepped = {1'b0, current} + {1'b0, max_step};
      end
    end

    next_duty = stepped[DUTY_WIDTH-1:0];
    if (stepped < {1'b0, DUTY_MIN}) begin
      next_duty = DUTY_MIN;
    end else if (stepped > {1'b0, DUTY_MAX}) begin
      next_duty = DUTY_MAX;
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty command sequencer for the PWM core: clamps commands, soft-starts, slews per carrier period, latches faults.
// All outputs registered (one cycle); o_cmd_ready drops only while in FAULT.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int STEP              = 4,
  parameter int SOFTSTART_PERIODS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_period_tick,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [DUTY_WIDTH-1:0] i_cmd_duty,
  input  logic                  i_fault,
  input  logic                  i_fault_clear,
  output logic [DUTY_WIDTH-1:0] o_duty,
  output logic                  o_pwm_enable,
  output logic                  o_at_target,
  output logic [1:0]            o_state
);

  localparam int CNT_W = $clog2(SOFTSTART_PERIODS + 1);

  state_t           state, state_nxt;
  duty_t            target, target_nxt;
  duty_t            duty_nxt, slew_duty, max_step, cmd_clamped;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             accept;

  assign o_cmd_ready = (state != FAULT);
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign o_state     = state;
  assign max_step    = (state == RUN) ? duty_t'(STEP) : duty_t'(1);
  assign cnt_inc     = cnt + CNT_W'(1);

  always_comb begin
    cmd_clamped = i_cmd_duty;
    if (i_cmd_duty < DUTY_MIN) begin
      cmd_clamped = DUTY_MIN;
    end else if (i_cmd_duty > DUTY_MAX) begin
      cmd_clamped = DUTY_MAX;
    end
  end

  pwm_slew_step u_slew (
    .current   (o_duty),
    .target    (target),
    .max_step  (max_step),
    .next_duty (slew_duty)
  );

  always_comb begin
    state_nxt  = state;
    duty_nxt   = o_duty;
    cnt_nxt    = cnt;
    // A completed handshake is never dropped, even when a fault or disable wins the cycle.
    target_nxt = accept ? cmd_clamped : target;

    if (i_fault) begin
      state_nxt = FAULT;
      duty_nxt  = DUTY_MIN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          duty_nxt = DUTY_MIN;
          cnt_nxt  = '0;
          if (i_enable) begin
            state_nxt = SOFTSTART;
          end
        end
        SOFTSTART: begin
          if (!i_enable) begin
            state_nxt = IDLE;
            duty_nxt  = DUTY_MIN;
            cnt_nxt   = '0;
          end else if (i_period_tick) begin
            duty_nxt = slew_duty;
            cnt_nxt  = cnt_inc;
            if (cnt_inc >= CNT_W'(SOFTSTART_PERIODS)) begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (!i_enable) begin
            state_nxt = IDLE;
            duty_nxt  = DUTY_MIN;
            cnt_nxt   = '0;
          end else if (i_period_tick) begin
            duty_nxt = slew_duty;
          end
        end
        FAULT: begin
          duty_nxt = DUTY_MIN;
          cnt_nxt  = '0;
          if (i_fault_clear && !i_enable) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = FAULT;
          duty_nxt  = DUTY_MIN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      target       <= DUTY_MIN;
      o_duty       <= DUTY_MIN;
      cnt          <= '0;
      o_pwm_enable <= 1'b0;
      o_at_target  <= 1'b0;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      o_duty       <= duty_nxt;
      cnt          <= cnt_nxt;
      o_pwm_enable <= (state_nxt == SOFTSTART) || (state_nxt == RUN);
      o_at_target  <= (state_nxt == RUN) && (duty_nxt == target_nxt);
    end
  end

endmodule
